// File: rtl/gen_inmediato_pipe.sv
`default_nettype none
// ============================================================================
// gen_inmediato_pipe: RV immediate extractor feeding a DEPTH-entry output FIFO
// Revision: 1.0
// ============================================================================
module gen_inmediato_pipe #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int TAG_W = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                instr,
  input  logic [2:0]                 imm_src,
  input  logic [TAG_W-1:0]           in_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            imm,
  output logic [TAG_W-1:0]           out_tag,
  output logic                       imm_err,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] c_full  = CNT_W'(DEPTH);
  localparam logic [2:0]       c_fmt_i = 3'b000;
  localparam logic [2:0]       c_fmt_s = 3'b001;
  localparam logic [2:0]       c_fmt_b = 3'b010;
  localparam logic [2:0]       c_fmt_u = 3'b011;
  localparam logic [2:0]       c_fmt_j = 3'b100;
  localparam logic [2:0]       c_fmt_z = 3'b101;

  logic [31:0]      w_imm32;
  logic             w_err;
  logic [XLEN-1:0]  w_wdata;
  logic             w_push;
  logic             w_pop;
  logic             w_unused_opcode;

  logic [XLEN-1:0]  r_mem_imm [DEPTH];
  logic [TAG_W-1:0] r_mem_tag [DEPTH];
  logic             r_mem_err [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  // The opcode field never contributes to any immediate.
  assign w_unused_opcode = ^instr[6:0];

  always_comb begin
    w_imm32 = '0;
    w_err   = 1'b0;
    case (imm_src)
      c_fmt_i: w_imm32 = {{20{instr[31]}}, instr[31:20]};
      c_fmt_s: w_imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      c_fmt_b: w_imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                          instr[11:8], 1'b0};
      c_fmt_u: w_imm32 = {instr[31:12], 12'b0};
      c_fmt_j: w_imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                          instr[30:21], 1'b0};
      c_fmt_z: w_imm32 = {27'b0, instr[19:15]};
      default: w_err   = 1'b1;
    endcase
  end

  // Every 32-bit form is already sign-correct, so widening is a plain bit-31 extension.
  generate
    if (XLEN > 32) begin : g_ext_wide
      assign w_wdata = {{(XLEN-32){w_imm32[31]}}, w_imm32};
    end else begin : g_ext_narrow
      assign w_wdata = w_imm32;
    end
  endgenerate

  assign in_ready  = (r_count != c_full);
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r_mem_imm[k] <= '0;
        r_mem_tag[k] <= '0;
        r_mem_err[k] <= 1'b0;
      end
    end else begin
      if (w_push) begin
        r_mem_imm[r_wr_ptr] <= w_wdata;
        r_mem_tag[r_wr_ptr] <= in_tag;
        r_mem_err[r_wr_ptr] <= w_err;
        r_wr_ptr            <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign imm     = r_mem_imm[r_rd_ptr];
  assign out_tag = r_mem_tag[r_rd_ptr];
  assign imm_err = r_mem_err[r_rd_ptr];
  assign count   = r_count;

endmodule
`default_nettype wire

// File: tb/tb_gen_inmediato_pipe.sv
`default_nettype none
// Bench for gen_inmediato_pipe: XLEN=32 scoreboard-checked FIFO plus XLEN=64 spot checks.
module tb_gen_inmediato_pipe;
  localparam int DEPTH = 2;
  localparam int TAG_W = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      instr = '0;
  logic [2:0]       imm_src = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      imm;
  logic [TAG_W-1:0] out_tag;
  logic             imm_err;
  logic [1:0]       count;

  logic             w_in_valid = 1'b0;
  logic             w_in_ready;
  logic [31:0]      w_instr = '0;
  logic [2:0]       w_src = '0;
  logic [TAG_W-1:0] w_tag_in = '0;
  logic             w_out_valid;
  logic [63:0]      w_imm;
  logic [TAG_W-1:0] w_tag_out;
  logic             w_imm_err;
  logic [1:0]       w_count;

  gen_inmediato_pipe #(.XLEN(32), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .imm_src(imm_src), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .imm(imm), .out_tag(out_tag), .imm_err(imm_err),
    .count(count)
  );

  gen_inmediato_pipe #(.XLEN(64), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .instr(w_instr), .imm_src(w_src), .in_tag(w_tag_in), .out_valid(w_out_valid),
    .out_ready(1'b1), .imm(w_imm), .out_tag(w_tag_out), .imm_err(w_imm_err),
    .count(w_count)
  );

  typedef struct packed {
    logic [31:0]      imm;
    logic [TAG_W-1:0] tag;
    logic             err;
  } sb_t;

  typedef struct {
    logic [31:0]      instr;
    logic [2:0]       src;
    logic [TAG_W-1:0] tag;
    logic [31:0]      exp;
    logic             err;
  } vec_t;

  sb_t         q[$];
  int          checks = 0;
  int          errors = 0;
  logic        mon_en = 1'b0;
  logic [31:0] exp_imm = '0;
  logic        exp_err = 1'b0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] ref_imm(logic [31:0] i, logic [2:0] s);
    logic [31:0] r;
    r = '0;
    case (s)
      3'd0: r = 32'($signed(i) >>> 20);
      3'd1: r = 32'($signed({i[31:25], i[11:7], 20'b0}) >>> 20);
      3'd2: r = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0, 19'b0}) >>> 19);
      3'd3: r = i & 32'hFFFF_F000;
      3'd4: r = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0, 11'b0}) >>> 11);
      3'd5: r = 32'(i[19:15]);
      default: r = '0;
    endcase
    return r;
  endfunction

  // Scoreboard: inputs and outputs are stable at the falling edge.
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      chk("count", 64'(count), 64'(q.size()));
      chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
      chk("in_ready", 64'(in_ready), 64'(q.size() != DEPTH));
      if (out_valid && q.size() != 0) begin
        chk("head_imm", 64'(imm), 64'(q[0].imm));
        chk("head_tag", 64'(out_tag), 64'(q[0].tag));
        chk("head_err", 64'(imm_err), 64'(q[0].err));
      end
      if (out_valid && out_ready && q.size() != 0) void'(q.pop_front());
      if (in_valid && in_ready) q.push_back('{exp_imm, in_tag, exp_err});
    end
  end

  task automatic drive(input logic [31:0] i, input logic [2:0] s, input logic [TAG_W-1:0] t,
                       input logic [31:0] e, input logic err);
    instr = i; imm_src = s; in_tag = t; exp_imm = e; exp_err = err; in_valid = 1'b1;
  endtask

  task automatic wait_accept();
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) chk("accept_timeout", 64'(n), 64'(0));
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send(input logic [31:0] i, input logic [2:0] s, input logic [TAG_W-1:0] t,
                      input logic [31:0] e, input logic err);
    drive(i, s, t, e, err);
    wait_accept();
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    chk("drain", 64'(q.size()), 64'(0));
    #1;
  endtask

  task automatic run64(input string nm, input logic [31:0] i, input logic [2:0] s,
                       input logic [63:0] e);
    w_instr = i; w_src = s; w_tag_in = 5'd3; w_in_valid = 1'b1;
    @(posedge clk);
    #1 w_in_valid = 1'b0;
    chk({nm, "_valid"}, 64'(w_out_valid), 64'(1));
    chk({nm, "_imm"}, w_imm, e);
    chk({nm, "_err"}, 64'(w_imm_err), 64'(0));
    @(posedge clk);
    #1 chk({nm, "_popped"}, 64'(w_out_valid), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[7];
    tbl[0] = '{32'hFE112E23, 3'd1, 5'd2, 32'hFFFFFFFC, 1'b0};
    tbl[1] = '{32'hFE000FE3, 3'd2, 5'd3, 32'hFFFFFFFE, 1'b0};
    tbl[2] = '{32'h123450B7, 3'd3, 5'd4, 32'h12345000, 1'b0};
    tbl[3] = '{32'hFFDFF06F, 3'd4, 5'd5, 32'hFFFFFFFC, 1'b0};
    tbl[4] = '{32'h000F9073, 3'd5, 5'd6, 32'h0000001F, 1'b0};
    tbl[5] = '{32'h7FF00093, 3'd0, 5'd7, 32'h000007FF, 1'b0};
    tbl[6] = '{32'h00000FA3, 3'd1, 5'd8, 32'h0000001F, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_imm", 64'(imm), 64'(0));
    chk("rst_tag", 64'(out_tag), 64'(0));
    chk("rst_err", 64'(imm_err), 64'(0));
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    run64("x64_u", 32'h800000B7, 3'd3, 64'hFFFFFFFF80000000);
    run64("x64_i", 32'h7FF00093, 3'd0, 64'h00000000000007FF);
    run64("x64_j", 32'hFFDFF06F, 3'd4, 64'hFFFFFFFFFFFFFFFC);

    out_ready = 1'b0;
    send(32'hFFF00093, 3'd0, 5'd1, 32'hFFFFFFFF, 1'b0);
    chk("lat_valid", 64'(out_valid), 64'(1));
    chk("lat_imm", 64'(imm), 64'hFFFFFFFF);
    chk("lat_tag", 64'(out_tag), 64'(1));
    chk("lat_err", 64'(imm_err), 64'(0));
    chk("lat_count", 64'(count), 64'(1));
    drain();

    for (int k = 0; k < 7; k++) begin
      send(tbl[k].instr, tbl[k].src, tbl[k].tag, tbl[k].exp, tbl[k].err);
    end
    drain();

    out_ready = 1'b0;
    send(32'h00100093, 3'd0, 5'd10, 32'h00000001, 1'b0);
    send(32'h00200093, 3'd0, 5'd11, 32'h00000002, 1'b0);
    drive(32'h00300093, 3'd0, 5'd12, 32'h00000003, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("full_in_ready", 64'(in_ready), 64'(0));
      chk("full_count", 64'(count), 64'(2));
      chk("full_head", 64'(imm), 64'(1));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("freed_in_ready", 64'(in_ready), 64'(1));
    chk("freed_count", 64'(count), 64'(1));
    wait_accept();
    chk("refill_count", 64'(count), 64'(2));
    drain();

    fork
      begin
        for (int k = 0; k < 5; k++) begin
          logic [31:0] ri;
          logic [2:0]  rs;
          ri = $urandom();
          rs = 3'($urandom_range(0, 5));
          send(ri, rs, 5'(20 + k), ref_imm(ri, rs), 1'b0);
          if ($urandom_range(0, 1) == 1) @(posedge clk);
          #1;
        end
      end
      begin
        repeat (40) begin
          @(posedge clk);
          #1 out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    drain();

    send(32'hFFFFFFFF, 3'b110, 5'd9, 32'h0, 1'b1);
    send(32'hFFFFFFFF, 3'b111, 5'd13, 32'h0, 1'b1);
    send(32'h00500093, 3'd0, 5'd14, 32'h00000005, 1'b0);
    drain();

    out_ready = 1'b0;
    send(32'h00600093, 3'd0, 5'd15, 32'h00000006, 1'b0);
    send(32'h00700093, 3'd0, 5'd16, 32'h00000007, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    q.delete();
    chk("arst_out_valid", 64'(out_valid), 64'(0));
    chk("arst_count", 64'(count), 64'(0));
    chk("arst_in_ready", 64'(in_ready), 64'(1));
    chk("arst_imm", 64'(imm), 64'(0));
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_valid", 64'(out_valid), 64'(0));
    send(32'h00800093, 3'd0, 5'd17, 32'h00000008, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
